// File: rtl/mux9_rr_arbiter_if.sv
// Bundle of the nine producer lanes, their request/grant lines and the
// registered output handshake of the round-robin arbiter.
interface mux9_rr_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h, i;
    logic [8:0]       req;
    logic [8:0]       gnt;
    logic [WIDTH-1:0] out;
    logic [3:0]       out_sel;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  a, b, c, d, e, f, g, h, i,
        input  req,
        input  out_ready,
        output gnt,
        output out,
        output out_sel,
        output out_valid
    );

    modport master (
        output a, b, c, d, e, f, g, h, i,
        output req,
        output out_ready,
        input  gnt,
        input  out,
        input  out_sel,
        input  out_valid
    );
endinterface

// File: rtl/mux9_rr_arbiter.sv
// Nine-lane round-robin arbiter feeding a one-entry valid/ready output stage.
// Define MUX9_BURST_EN to let a lane keep the pointer for up to MAX_BURST grants.
module mux9_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input logic               clk,
    input logic               resetn,
    mux9_rr_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_outSel;
    logic [3:0]       r_ptr;

    logic             w_load;
    logic             w_found;
    logic [3:0]       w_winner;
    logic [3:0]       w_advPtr;
    logic [WIDTH-1:0] w_lanes [9];
    logic [WIDTH-1:0] w_data;

    assign w_lanes[0] = bus.a;
    assign w_lanes[1] = bus.b;
    assign w_lanes[2] = bus.c;
    assign w_lanes[3] = bus.d;
    assign w_lanes[4] = bus.e;
    assign w_lanes[5] = bus.f;
    assign w_lanes[6] = bus.g;
    assign w_lanes[7] = bus.h;
    assign w_lanes[8] = bus.i;

    assign w_load = (r_state == ST_EMPTY) || bus.out_ready;

    // Cyclic priority search starting at the pointer; first requester wins.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = 4'd0;
        idx      = 0;
        for (int off = 0; off < 9; off++) begin
            idx = int'(r_ptr) + off;
            if (idx > 8) idx = idx - 9;
            if (!w_found && bus.req[idx]) begin
                w_found  = 1'b1;
                w_winner = 4'(idx);
            end
        end
    end

    assign w_data   = w_lanes[w_winner];
    assign w_advPtr = (w_winner == 4'd8) ? 4'd0 : w_winner + 4'd1;

    assign bus.gnt       = (resetn && w_load && w_found) ? (9'b1 << w_winner) : 9'b0;
    assign bus.out       = r_out;
    assign bus.out_sel   = r_outSel;
    assign bus.out_valid = (r_state == ST_FULL);

`ifdef MUX9_BURST_EN
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [3:0] r_burstCnt;
    logic [3:0] w_burstNext;
    logic [3:0] w_nextPtr;

    // The last granted lane is the one still recorded in r_outSel.
    always_comb begin
        w_burstNext = 4'd1;
        if (w_winner == r_outSel && r_burstCnt < BURST_MAX)
            w_burstNext = r_burstCnt + 4'd1;
        w_nextPtr = (w_burstNext < BURST_MAX) ? w_winner : w_advPtr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_burstCnt <= 4'd0;
        else if (w_load && w_found)
            r_burstCnt <= w_burstNext;
    end
`else
    logic [3:0] w_nextPtr;
    assign w_nextPtr = w_advPtr;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_EMPTY;
            r_out    <= {WIDTH{1'b1}};
            r_outSel <= 4'hF;
            r_ptr    <= 4'd0;
        end else if (w_load) begin
            if (w_found) begin
                r_state  <= ST_FULL;
                r_out    <= w_data;
                r_outSel <= w_winner;
                r_ptr    <= w_nextPtr;
            end else begin
                r_state  <= ST_EMPTY;
                r_out    <= {WIDTH{1'b1}};
                r_outSel <= 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Directed vector bench for mux9_rr_arbiter: reset, rotation, backpressure,
// wrap/skip, mid-hold reset, single lane and burst sequences.
module tb_mux9_rr_arbiter;

    typedef struct {
        logic        rst;
        logic [8:0]  req;
        logic        rdy;
        logic [8:0]  gnt;
        logic        valid;
        logic [3:0]  sel;
        logic [15:0] out;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic [8:0]  reqDrv;
    logic        readyDrv;
    logic [15:0] laneData [9];
    int          total;
    int          bad;
    vec_t        vecs[$];
    int          expSeq[$];

    mux9_rr_arbiter_if #(.WIDTH(16)) bus ();

    assign bus.a         = laneData[0];
    assign bus.b         = laneData[1];
    assign bus.c         = laneData[2];
    assign bus.d         = laneData[3];
    assign bus.e         = laneData[4];
    assign bus.f         = laneData[5];
    assign bus.g         = laneData[6];
    assign bus.h         = laneData[7];
    assign bus.i         = laneData[8];
    assign bus.req       = reqDrv;
    assign bus.out_ready = readyDrv;

    mux9_rr_arbiter #(.WIDTH(16), .MAX_BURST(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addVec(input logic rst, input logic [8:0] req, input logic rdy,
                          input logic [8:0] gnt, input logic valid,
                          input logic [3:0] sel, input logic [15:0] out);
        vec_t v;
        v.rst = rst; v.req = req; v.rdy = rdy;
        v.gnt = gnt; v.valid = valid; v.sel = sel; v.out = out;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic rst, input logic [8:0] req, input logic rdy);
        @(negedge clk);
        resetn   = !rst;
        reqDrv   = req;
        readyDrv = rdy;
        #1;
    endtask

    task automatic checkField(input string name, input int idx,
                              input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [8:0] gnt,
                               input logic valid, input logic [3:0] sel, input logic [15:0] out);
        checkField({name, ".gnt"}, idx, 16'(bus.gnt), 16'(gnt));
        checkField({name, ".valid"}, idx, 16'(bus.out_valid), 16'(valid));
        checkField({name, ".sel"}, idx, 16'(bus.out_sel), 16'(sel));
        checkField({name, ".out"}, idx, bus.out, out);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        resetn   = 1'b0;
        reqDrv   = 9'h000;
        readyDrv = 1'b1;
        for (int k = 0; k < 9; k++) laneData[k] = 16'h0A00 + 16'(k);

        // Reset with requests pending, then idle.
        addVec(1, 9'h1FF, 1, 9'h000, 0, 4'hF, 16'hFFFF);
        addVec(1, 9'h1FF, 1, 9'h000, 0, 4'hF, 16'hFFFF);
        for (int k = 0; k < 5; k++) addVec(0, 9'h000, 1, 9'h000, 0, 4'hF, 16'hFFFF);
        // Full rotation 0..8,0 then drain.
        addVec(0, 9'h1FF, 1, 9'h001, 0, 4'hF, 16'hFFFF);
        for (int k = 0; k < 8; k++)
            addVec(0, 9'h1FF, 1, 9'(1 << (k + 1)), 1, 4'(k), 16'h0A00 + 16'(k));
        addVec(0, 9'h1FF, 1, 9'h001, 1, 4'd8, 16'h0A08);
        addVec(0, 9'h000, 1, 9'h000, 1, 4'd0, 16'h0A00);
        addVec(0, 9'h000, 1, 9'h000, 0, 4'hF, 16'hFFFF);
        // Reset brings the pointer back to 0, then backpressure.
        addVec(1, 9'h000, 1, 9'h000, 0, 4'hF, 16'hFFFF);
        addVec(0, 9'h003, 1, 9'h001, 0, 4'hF, 16'hFFFF);
        addVec(0, 9'h003, 0, 9'h000, 1, 4'd0, 16'h0A00);
        addVec(0, 9'h003, 0, 9'h000, 1, 4'd0, 16'h0A00);
        addVec(0, 9'h003, 0, 9'h000, 1, 4'd0, 16'h0A00);
        addVec(0, 9'h003, 1, 9'h002, 1, 4'd0, 16'h0A00);
        addVec(0, 9'h000, 1, 9'h000, 1, 4'd1, 16'h0A01);
        addVec(0, 9'h000, 1, 9'h000, 0, 4'hF, 16'hFFFF);
        // Reset during a stalled hold drops the word.
        addVec(0, 9'h003, 1, 9'h001, 0, 4'hF, 16'hFFFF);
        addVec(0, 9'h003, 0, 9'h000, 1, 4'd0, 16'h0A00);
        addVec(1, 9'h003, 0, 9'h000, 0, 4'hF, 16'hFFFF);
        addVec(0, 9'h000, 0, 9'h000, 0, 4'hF, 16'hFFFF);
        // Lane 7 moves the pointer to 8; then wrap and skip between 8 and 0.
        addVec(0, 9'h080, 0, 9'h080, 0, 4'hF, 16'hFFFF);
        addVec(0, 9'h101, 1, 9'h100, 1, 4'd7, 16'h0A07);
        addVec(0, 9'h101, 1, 9'h001, 1, 4'd8, 16'h0A08);
        addVec(0, 9'h101, 1, 9'h100, 1, 4'd0, 16'h0A00);
        addVec(0, 9'h000, 1, 9'h000, 1, 4'd8, 16'h0A08);
        addVec(0, 9'h000, 1, 9'h000, 0, 4'hF, 16'hFFFF);

`ifndef MUX9_BURST_EN
        for (int n = 0; n < vecs.size(); n++) begin
            applyStimulus(vecs[n].rst, vecs[n].req, vecs[n].rdy);
            checkOutput("vec", n, vecs[n].gnt, vecs[n].valid, vecs[n].sel, vecs[n].out);
        end
`else
        applyStimulus(1, 9'h000, 1);
        checkOutput("rst", 0, 9'h000, 0, 4'hF, 16'hFFFF);
`endif

        // Single requester: granted every cycle, data visible one cycle later.
        laneData[4] = 16'h1234;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(0, 9'h010, 1);
            if (n == 0) checkOutput("single", n, 9'h010, 0, 4'hF, 16'hFFFF);
            else        checkOutput("single", n, 9'h010, 1, 4'd4, 16'h1234);
        end
        applyStimulus(0, 9'h000, 1);
        checkOutput("single", 4, 9'h000, 1, 4'd4, 16'h1234);
        applyStimulus(0, 9'h000, 1);
        checkOutput("single", 5, 9'h000, 0, 4'hF, 16'hFFFF);
        laneData[4] = 16'h0A04;

        // Two lanes held from a fresh pointer: alternation or bursts of four.
        applyStimulus(1, 9'h000, 1);
`ifdef MUX9_BURST_EN
        expSeq = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
`else
        expSeq = '{1, 2, 1, 2};
`endif
        for (int n = 0; n < expSeq.size(); n++) begin
            applyStimulus(0, 9'h006, 1);
            if (n == 0) checkOutput("burst", n, 9'h002, 0, 4'hF, 16'hFFFF);
            else        checkOutput("burst", n, 9'(1 << expSeq[n]), 1, 4'(expSeq[n-1]),
                                    16'h0A00 + 16'(expSeq[n-1]));
        end
        applyStimulus(0, 9'h000, 1);
        checkOutput("burst", expSeq.size(), 9'h000, 1, 4'(expSeq[expSeq.size()-1]),
                    16'h0A00 + 16'(expSeq[expSeq.size()-1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux9_rr_arbiter.md
Name: mux9_rr_arbiter

Overview:
- Round-robin arbiter sharing one 16-bit output channel among nine requesters (a..i).
- Drives the 4-bit select of a 9:1 mux internally.
- Registers the selected word into a one-entry output stage with valid/ready handshake.
- Sits between nine producer lanes and a single downstream consumer that may stall.

Parameters:
- WIDTH, 16, data width of each lane and of out.
- MAX_BURST, 4, maximum consecutive grants to one lane. Used only with MUX9_BURST_EN; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- a..i  input  WIDTH each  lane data; lane index a=0 .. i=8.
- req  input  9  per-lane request; bit k belongs to lane k.
- gnt  output  9  one-hot combinational accept. Bit k high means lane k's word is captured at this clock edge. All-zero when nothing is captured.
- out  output  WIDTH  registered selected data.
- out_sel  output  4  registered index of the lane held in out.
- out_valid  output  1  out holds a word.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.

Behaviour:
- Reset (resetn low, asynchronous):
  - out_valid=0, out=16'hFFFF, out_sel=4'hF, rr pointer=0, burst count=0.
  - gnt is all-zero while in reset.
  - A reset in the middle of a hold drops the held word; no gnt is issued during reset.
- State machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load enable: load = (EMPTY) or (FULL and out_ready).
- Winner selection:
  - Search req cyclically starting at the rr pointer: ptr, ptr+1, ..., 8, 0, ..., ptr-1.
  - The first set bit is the winner.
- If load is high and req is non-zero:
  - gnt[winner]=1.
  - Next edge: out <= lane data, out_sel <= winner, out_valid <= 1, ptr <= (winner==8) ? 0 : winner+1.
- If load is high and req is zero:
  - gnt=0.
  - Next edge: out_valid <= 0, out <= 16'hFFFF, out_sel <= 4'hF, ptr unchanged.
- If FULL and not out_ready: gnt=0; all registers hold.
- Latency: one cycle from gnt to out_valid. Back-to-back throughput of one word per cycle when out_ready stays high.
- Drain and refill in the same cycle: a word is consumed and a new word is loaded on the same edge, with no bubble.
- Requests and gnt:
  - A requester keeps req and its data stable until it sees gnt. It may then drop req or present the next word.
  - req deasserted before gnt is legal; the lane simply loses eligibility.
  - gnt never asserts for a lane whose req is low.
- Fairness: any continuously requesting lane is granted within 9 loads.
- out_sel never takes values 9..14. The value 15 only appears with out_valid=0.

Optional Feature:
- MUX9_BURST_EN defined:
  - After a grant to lane k, the pointer stays at k while req[k] remains high and the burst count is below MAX_BURST.
  - The burst count increments on each grant to k and resets to 1 on a grant to another lane.
  - When the count reaches MAX_BURST, or req[k] drops, the pointer advances to k+1 as normal.
  - Fairness bound becomes 8*MAX_BURST+1 loads.
- MUX9_BURST_EN undefined: pure one-grant round-robin. The burst counter is absent and MAX_BURST is ignored.

Test Plan:
- Reset then idle: resetn low for 2 cycles, then req=0 for 5 cycles. Expect out_valid=0, out=16'hFFFF, out_sel=4'hF and gnt=0 throughout.
- Single lane: req=9'h010, e=16'h1234, out_ready=1. Expect gnt=9'h010 each cycle. Expect out=16'h1234 and out_sel=4 from the cycle after the first gnt.
- Full rotation: req=9'h1FF held, lane k data = 16'h0A00+k, out_ready=1. Expect out_sel sequence 0,1,...,8,0 and out matching the lane data, one word per cycle.
- Backpressure: req=9'h003, out_ready=0 for 3 cycles after the first load.
  - Expect out=a and out_sel=0 held, gnt=0 during the stall.
  - On release, expect out_sel=1 captured in the same cycle the word is consumed.
- Wrap and skip: ptr=8 (last grant was lane 7), req=9'h101. Expect lane 8 granted, then lane 0, then lane 8.
- Burst (MUX9_BURST_EN, MAX_BURST=4): req=9'h006 held, out_ready=1. Expect out_sel 1,1,1,1,2,2,2,2,1. Without the macro, expect 1,2,1,2.
